// File: rtl/layer_output_serializer_pkg.sv
// layer_output_serializer_pkg: shared layer sizing constants and serializer FSM state encoding
package layer_output_serializer_pkg;
    localparam int LOS_NUM_NEURONS = 30;
    localparam int LOS_DATA_WIDTH  = 8;
    typedef enum logic {
        S_COLLECT = 1'b0,
        S_SHIFT   = 1'b1
    } state_t;
endpackage

// File: rtl/layer_output_serializer_capture_bank.sv
// layer_output_serializer_capture_bank: per-neuron activation capture registers plus arrival flags
//   i_en     captures allowed this cycle (COLLECT)
//   i_clear  drop all flags (last element of the stream transferred)
//   i_valid  per-neuron outvalid pulses, i_data packed activations
//   o_cap    captured activations, o_all every flag set counting this cycle's captures
module layer_output_serializer_capture_bank
    import layer_output_serializer_pkg::*;
#(
    parameter int NUM_NEURONS = LOS_NUM_NEURONS,
    parameter int DATA_WIDTH  = LOS_DATA_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_en,
    input  logic                              i_clear,
    input  logic [NUM_NEURONS-1:0]            i_valid,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0]             o_cap [NUM_NEURONS],
    output logic                              o_all
);
    logic [NUM_NEURONS-1:0] r_flag;
    logic [NUM_NEURONS-1:0] w_take;

    assign w_take = i_en ? i_valid : '0;
    assign o_all  = &(r_flag | w_take);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag <= '0;
            for (int k = 0; k < NUM_NEURONS; k++) o_cap[k] <= '0;
        end else begin
            r_flag <= i_clear ? '0 : (r_flag | w_take);
            for (int k = 0; k < NUM_NEURONS; k++)
                if (w_take[k]) o_cap[k] <= i_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end
endmodule

// File: rtl/layer_output_serializer.sv
// layer_output_serializer: gathers one layer's neuron activations and streams them in neuron order
//   nrn_out/nrn_valid  packed activations and outvalid pulses of the producing layer
//   out_ready          downstream accepts the current element
//   out_data/out_valid/out_index/out_last  registered serial stream
//   busy               streaming, overrun sticky flag for pulses dropped while streaming
module layer_output_serializer
    import layer_output_serializer_pkg::*;
#(
    parameter int NUM_NEURONS = LOS_NUM_NEURONS,
    parameter int DATA_WIDTH  = LOS_DATA_WIDTH,
    parameter int IDX_WIDTH   = $clog2(NUM_NEURONS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] nrn_out,
    input  logic [NUM_NEURONS-1:0]            nrn_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_valid,
    output logic [IDX_WIDTH-1:0]              out_index,
    output logic                              out_last,
    output logic                              busy,
    output logic                              overrun
);
    state_t                 r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0]  w_cap [NUM_NEURONS];
    logic                   w_all, w_load, w_xfer, w_done;
    logic [IDX_WIDTH-1:0]   w_ptr_inc, w_index_nxt;
    logic [DATA_WIDTH-1:0]  w_data_nxt;
    logic                   w_valid_nxt, w_last_nxt;

    layer_output_serializer_capture_bank #(
        .NUM_NEURONS(NUM_NEURONS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_state == S_COLLECT),
        .i_clear(w_done),
        .i_valid(nrn_valid),
        .i_data (nrn_out),
        .o_cap  (w_cap),
        .o_all  (w_all)
    );

    assign w_load    = (r_state == S_COLLECT) && w_all;
    assign w_xfer    = out_valid && out_ready;
    assign w_done    = w_xfer && out_last;
    assign w_ptr_inc = out_index + 1'b1;
    assign busy      = (r_state == S_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_COLLECT;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_last  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            out_data  <= w_data_nxt;
            out_valid <= w_valid_nxt;
            out_index <= w_index_nxt;
            out_last  <= w_last_nxt;
            overrun   <= overrun | ((r_state == S_SHIFT) && |nrn_valid);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_COLLECT && w_all) w_state_nxt = S_SHIFT;
        if (r_state == S_SHIFT && w_done)  w_state_nxt = S_COLLECT;
    end

    // Element 0 may arrive in the very cycle the bank completes, so bypass its capture register.
    always_comb begin
        w_valid_nxt = out_valid;
        w_index_nxt = out_index;
        w_data_nxt  = out_data;
        w_last_nxt  = out_last;
        if (w_load) begin
            w_valid_nxt = 1'b1;
            w_index_nxt = '0;
            w_data_nxt  = nrn_valid[0] ? nrn_out[DATA_WIDTH-1:0] : w_cap[0];
            w_last_nxt  = 1'b0;
        end else if (w_done) begin
            w_valid_nxt = 1'b0;
            w_index_nxt = '0;
            w_data_nxt  = '0;
            w_last_nxt  = 1'b0;
        end else if (w_xfer) begin
            w_index_nxt = w_ptr_inc;
            w_data_nxt  = w_cap[w_ptr_inc];
            w_last_nxt  = (w_ptr_inc == IDX_WIDTH'(NUM_NEURONS - 1));
        end
    end
endmodule

// File: tb/tb_layer_output_serializer.sv
// tb_layer_output_serializer: directed and randomized checks of the layer output serializer
module tb_layer_output_serializer;
    localparam int N  = 30;
    localparam int DW = 8;
    localparam int IW = $clog2(N);

    typedef struct {
        logic [DW-1:0] d;
        int            idx;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N*DW-1:0]   nrn_out = '0;
    logic [N-1:0]      nrn_valid = '0;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic [IW-1:0]     out_index;
    logic              out_last;
    logic              busy;
    logic              overrun;

    int                tests = 0;
    int                fails = 0;
    int                xfers = 0;
    ent_t              q[$];
    logic [DW-1:0]     m_cap [N];
    logic [N-1:0]      m_flag = '0;
    logic              m_stream = 1'b0;
    logic              m_ovr = 1'b0;
    logic [N*DW-1:0]   fixed_d;
    localparam logic [N-1:0] ALL = '1;

    layer_output_serializer dut (
        .clk      (clk),
        .rst      (rst),
        .nrn_out  (nrn_out),
        .nrn_valid(nrn_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_index(out_index),
        .out_last (out_last),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] rnd_data();
        logic [N*DW-1:0] r;
        for (int k = 0; k < N; k++) r[k*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    // One clock: compare current outputs with the model, apply inputs, advance the model.
    task automatic cyc(input logic [N*DW-1:0] d, input logic [N-1:0] v, input logic rdy);
        chk("busy", 32'(busy), 32'(m_stream));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("valid", 32'(out_valid), 32'(m_stream));
        if (m_stream) begin
            chk("data", 32'(out_data), 32'(q[0].d));
            chk("index", 32'(out_index), 32'(q[0].idx));
            chk("last", 32'(out_last), 32'(q[0].idx == N - 1));
        end
        if (out_valid && rdy) xfers++;
        nrn_out = d;
        nrn_valid = v;
        out_ready = rdy;
        if (m_stream) begin
            if (v != '0) m_ovr = 1'b1;
            if (rdy) begin
                void'(q.pop_front());
                if (q.size() == 0) m_stream = 1'b0;
            end
        end else begin
            for (int k = 0; k < N; k++)
                if (v[k]) begin
                    m_cap[k] = d[k*DW +: DW];
                    m_flag[k] = 1'b1;
                end
            if (&m_flag) begin
                for (int k = 0; k < N; k++) q.push_back('{d: m_cap[k], idx: k});
                m_flag = '0;
                m_stream = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nrn_valid = '0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_flag = '0;
        m_stream = 1'b0;
        m_ovr = 1'b0;
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_index", 32'(out_index), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
    endtask

    task automatic drain();
        for (int g = 0; g < 40 && m_stream; g++) cyc(rnd_data(), '0, 1'b1);
        cyc(rnd_data(), '0, 1'b1);
    endtask

    initial begin
        for (int k = 0; k < N; k++) m_cap[k] = '0;
        @(negedge clk);
        do_reset();

        // all valid at once, fixed data k+16
        for (int k = 0; k < N; k++) fixed_d[k*DW +: DW] = DW'(k + 16);
        xfers = 0;
        cyc(fixed_d, ALL, 1'b1);
        chk("t1_first_valid", 32'(out_valid), 32'd1);
        chk("t1_first_data", 32'(out_data), 32'd16);
        drain();
        chk("t1_xfers", 32'(xfers), 32'd30);

        // staggered arrival, neuron k at cycle 2k
        for (int k = 0; k < N; k++) begin
            cyc(rnd_data(), N'(1) << k, 1'b1);
            cyc(rnd_data(), '0, 1'b1);
        end
        drain();

        // backpressure at index 5
        xfers = 0;
        cyc(rnd_data(), ALL, 1'b1);
        for (int i = 0; i < 5; i++) cyc(rnd_data(), '0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(rnd_data(), '0, 1'b0);
        drain();
        chk("t3_xfers", 32'(xfers), 32'd30);

        // overrun during streaming
        cyc(rnd_data(), ALL, 1'b1);
        for (int i = 0; i < 7; i++) cyc(rnd_data(), '0, 1'b1);
        cyc(rnd_data(), N'(1) << 3, 1'b1);
        drain();
        chk("t4_overrun_sticky", 32'(overrun), 32'd1);
        cyc(rnd_data(), ALL, 1'b1);
        drain();

        // reset in the middle of a stream, then partial arrival must not stream
        cyc(rnd_data(), ALL, 1'b1);
        for (int i = 0; i < 10; i++) cyc(rnd_data(), '0, 1'b1);
        chk("t5_pre_index", 32'(out_index), 32'd10);
        do_reset();
        for (int i = 0; i < 3; i++) cyc(rnd_data(), '0, 1'b1);
        cyc(rnd_data(), ALL >> 1, 1'b1);
        cyc(rnd_data(), '0, 1'b1);
        cyc(rnd_data(), N'(1) << (N - 1), 1'b1);
        drain();

        // back-to-back samples
        cyc(rnd_data(), ALL, 1'b1);
        for (int g = 0; g < 40 && m_stream; g++) cyc(rnd_data(), '0, 1'b1);
        cyc(rnd_data(), ALL, 1'b1);
        drain();
        chk("t6_overrun", 32'(overrun), 32'd0);

        // random arrival and random backpressure
        for (int s = 0; s < 4; s++) begin
            for (int g = 0; g < 200 && !m_stream; g++)
                cyc(rnd_data(), N'($urandom) & N'($urandom), 1'($urandom));
            for (int g = 0; g < 300 && m_stream; g++)
                cyc(rnd_data(), '0, 1'($urandom));
            chk("rand_stream_done", 32'(m_stream), 32'd0);
            cyc(rnd_data(), '0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
